// File: rtl/pwm_ramp_ctrl_if.sv
// Command/status bundle for pwm_ramp_ctrl: target duty and stop controls in,
// PWM drive and ramp status out.
interface pwm_ramp_ctrl_if;
  logic [9:0] target_width;
  logic       estop;
  logic       estop_clr;
  logic       pwm_out;
  logic [9:0] cur_width;
  logic       ramping;
  logic       at_target;
  logic       estop_active;

  modport master (
    output target_width, estop, estop_clr,
    input  pwm_out, cur_width, ramping, at_target, estop_active
  );

  modport slave (
    input  target_width, estop, estop_clr,
    output pwm_out, cur_width, ramping, at_target, estop_active
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Ramped motor PWM: slews cur_width toward target_width by STEP every RAMP_DIV cycles.
// Optional macro PWM_RAMP_ESTOP_LATCH_EN holds the stop until an estop_clr pulse.
module pwm_ramp_ctrl #(
  parameter int RAMP_DIV = 1000,
  parameter int STEP     = 10
) (
  input  logic           clock,
  input  logic           reset,
  pwm_ramp_ctrl_if.slave bus
);

  localparam int TW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_DIV - 1);
  localparam logic [9:0]    PER_LAST  = 10'd1022;
  localparam logic [10:0]   STEP_W    = 11'(STEP);

  typedef enum logic [1:0] {IDLE, RAMP, HOLD, ESTOP} state_e;

  state_e          state_q, state_d;
  logic [9:0]      period_q, period_d;
  logic [9:0]      duty_q, duty_d;
  logic [9:0]      cur_q, cur_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic            pwm_q, pwm_d;

  logic            period_wrap;
  logic            tick;
  logic            stopped;
  logic [9:0]      tgt;
  logic [10:0]     sum;
  logic [10:0]     diff;
  logic            below_step;
  logic [9:0]      ramp_val;

  assign tgt         = bus.target_width;
  assign period_wrap = (period_q == PER_LAST);
  assign tick        = (tick_q == TICK_LAST);
  assign stopped     = (state_q == ESTOP);

  // 11-bit headroom keeps cur+STEP from wrapping before the clamp.
  assign sum        = {1'b0, cur_q} + STEP_W;
  assign diff       = {1'b0, cur_q} - STEP_W;
  assign below_step = ({1'b0, cur_q} < STEP_W);

  always_comb begin
    ramp_val = cur_q;
    if (cur_q < tgt)
      ramp_val = (sum > {1'b0, tgt}) ? tgt : sum[9:0];
    else if (cur_q > tgt)
      ramp_val = (below_step || (diff[9:0] < tgt)) ? tgt : diff[9:0];
  end

`ifndef PWM_RAMP_ESTOP_LATCH_EN
  logic unused_clr;
  assign unused_clr = bus.estop_clr;
`endif

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    tick_d   = tick ? '0 : tick_q + 1'b1;
    period_d = period_wrap ? 10'd0 : period_q + 10'd1;
    duty_d   = period_wrap ? cur_q : duty_q;
    pwm_d    = (period_q < duty_q);

    if (bus.estop) begin
      // Stop wins over a coincident tick; the ramp update is dropped.
      state_d = ESTOP;
      cur_d   = '0;
      duty_d  = '0;
      tick_d  = '0;
    end else if (stopped) begin
      cur_d  = '0;
      tick_d = '0;
`ifdef PWM_RAMP_ESTOP_LATCH_EN
      if (bus.estop_clr)
        state_d = IDLE;
`else
      state_d = IDLE;
`endif
    end else begin
      if (tick)
        cur_d = ramp_val;
      if ((cur_d == 10'd0) && (tgt == 10'd0))
        state_d = IDLE;
      else if (cur_d != tgt)
        state_d = RAMP;
      else
        state_d = HOLD;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      duty_q   <= '0;
      period_q <= '0;
      tick_q   <= '0;
      pwm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      tick_q   <= tick_d;
      pwm_q    <= pwm_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.cur_width    = cur_q;
  assign bus.ramping      = (state_q == RAMP);
  assign bus.estop_active = stopped;
  assign bus.at_target    = (cur_q == tgt) && !stopped;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed + randomized bench for pwm_ramp_ctrl (RAMP_DIV=4, STEP=10) against a
// cycle-level arithmetic reference model.
module tb_pwm_ramp_ctrl;
  localparam int DIV  = 4;
  localparam int STP  = 10;
`ifdef PWM_RAMP_ESTOP_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pwm_ramp_ctrl_if bus ();

  pwm_ramp_ctrl #(.RAMP_DIV(DIV), .STEP(STP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // driven inputs
  int d_tgt = 0;
  bit d_es  = 1'b0;
  bit d_clr = 1'b0;
  bit d_rst = 1'b1;

  // reference model: 0=IDLE 1=RAMP 2=HOLD 3=ESTOP
  int m_cur = 0, m_duty = 0, m_period = 0, m_tick = 0, m_state = 0;
  bit m_pwm = 1'b0;

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit wrap, tk;
    int n_duty;
    if (d_rst) begin
      m_cur = 0; m_duty = 0; m_period = 0; m_tick = 0; m_pwm = 0; m_state = 0;
      return;
    end
    m_pwm    = (m_period < m_duty);
    wrap     = (m_period == 1022);
    tk       = (m_tick == DIV - 1);
    n_duty   = wrap ? m_cur : m_duty;
    m_period = (m_period + 1) % 1023;
    m_tick   = (m_tick + 1) % DIV;
    if (d_es) begin
      m_state = 3; m_cur = 0; n_duty = 0; m_tick = 0;
    end else if (m_state == 3) begin
      m_tick = 0;
      if (!LATCH || d_clr) m_state = 0;
    end else begin
      if (tk) begin
        if (m_cur < d_tgt)      m_cur = (m_cur + STP > d_tgt) ? d_tgt : m_cur + STP;
        else if (m_cur > d_tgt) m_cur = (m_cur - STP < d_tgt) ? d_tgt : m_cur - STP;
      end
      if (m_cur == 0 && d_tgt == 0) m_state = 0;
      else if (m_cur != d_tgt)      m_state = 1;
      else                          m_state = 2;
    end
    m_duty = n_duty;
  endtask

  task automatic step();
    bus.target_width = 10'(d_tgt);
    bus.estop        = d_es;
    bus.estop_clr    = d_clr;
    reset            = d_rst;
    @(posedge clock);
    model_edge();
    #1;
    chk("cur_width",    11'(bus.cur_width),    11'(m_cur));
    chk("pwm_out",      11'(bus.pwm_out),      11'(m_pwm));
    chk("ramping",      11'(bus.ramping),      11'(m_state == 1));
    chk("estop_active", 11'(bus.estop_active), 11'(m_state == 3));
    chk("at_target",    11'(bus.at_target),    11'((m_cur == d_tgt) && (m_state != 3)));
  endtask

  // step until cur_width hits v; an expired bound is a failed comparison
  task automatic run_to(input int v, input int bound, input string tag);
    for (int i = 0; i < bound && bus.cur_width != 10'(v); i++) step();
    chk(tag, 11'(bus.cur_width), 11'(v));
  endtask

  task automatic count_period(input int change_at, input int new_tgt, output int cnt);
    cnt = 0;
    for (int i = 0; i < 1023; i++) begin
      if (i == change_at) d_tgt = new_tgt;
      step();
      if (bus.pwm_out === 1'b1) cnt++;
    end
  endtask

  task automatic align_period();
    for (int i = 0; i < 1100 && m_period != 0; i++) step();
  endtask

  initial begin
    int prev, cnt;
    bus.target_width = '0;
    bus.estop        = 1'b0;
    bus.estop_clr    = 1'b0;
    reset            = 1'b1;

    // reset state
    step(); step();
    chk("rst_cur", 11'(bus.cur_width), 11'd0);
    chk("rst_pwm", 11'(bus.pwm_out), 11'd0);
    chk("rst_at_target", 11'(bus.at_target), 11'd1);
    d_rst = 1'b0;

    // 0 -> 10 -> 20 -> 25 on ticks four cycles apart
    d_tgt = 25;
    step();
    chk("ramp_ramping", 11'(bus.ramping), 11'd1);
    step(); step(); step();
    chk("ramp_10", 11'(bus.cur_width), 11'd10);
    repeat (4) step();
    chk("ramp_20", 11'(bus.cur_width), 11'd20);
    repeat (4) step();
    chk("ramp_25", 11'(bus.cur_width), 11'd25);
    chk("hold_at_target", 11'(bus.at_target), 11'd1);
    chk("hold_not_ramping", 11'(bus.ramping), 11'd0);

    // ramp down from 1000 to 3; last step is 10 -> 3
    d_tgt = 1000;
    run_to(1000, 500, "up_1000");
    d_tgt = 3;
    prev = 1000;
    for (int i = 0; i < 500 && bus.cur_width != 10'd3; i++) begin
      prev = int'(bus.cur_width);
      step();
    end
    chk("down_3", 11'(bus.cur_width), 11'd3);
    chk("down_prev_10", 11'(prev), 11'd10);

    // duty 300: exactly 300 high cycles; mid-period change only hits the next period
    d_tgt = 300;
    run_to(300, 200, "up_300");
    step();
    align_period();
    count_period(100, 600, cnt);
    chk("pwm_count_300", 11'(cnt), 11'd300);
    align_period();
    count_period(2000, 600, cnt);
    chk("pwm_count_600", 11'(cnt), 11'd600);

    // estop pulse at cur=500
    d_tgt = 500;
    run_to(500, 200, "up_500");
    d_es = 1'b1; step(); d_es = 1'b0;
    chk("estop_cur0", 11'(bus.cur_width), 11'd0);
    chk("estop_active", 11'(bus.estop_active), 11'd1);
    step();
    chk("estop_pwm_low", 11'(bus.pwm_out), 11'd0);
    if (LATCH) begin
      repeat (5) step();
      chk("latch_held", 11'(bus.estop_active), 11'd1);
      d_clr = 1'b1; step(); d_clr = 1'b0;
    end
    chk("estop_released", 11'(bus.estop_active), 11'd0);
    for (int i = 0; i < 20 && bus.cur_width == 10'd0; i++) step();
    chk("restart_from_0", 11'(bus.cur_width), 11'd10);

    // estop coincident with a tick discards the step
    for (int i = 0; i < 40 && !(m_tick == DIV - 1 && m_cur > 0 && m_cur < d_tgt); i++) step();
    d_es = 1'b1; step(); d_es = 1'b0;
    chk("estop_tick_cur0", 11'(bus.cur_width), 11'd0);
    d_clr = 1'b1; step(); d_clr = 1'b0;

    // reset mid-ramp at cur=40
    d_tgt = 200;
    run_to(40, 100, "up_40");
    d_rst = 1'b1; step(); d_rst = 1'b0;
    chk("mid_rst_cur", 11'(bus.cur_width), 11'd0);
    chk("mid_rst_ramping", 11'(bus.ramping), 11'd0);
    chk("mid_rst_estop", 11'(bus.estop_active), 11'd0);
    chk("mid_rst_pwm", 11'(bus.pwm_out), 11'd0);
    chk("mid_rst_at_target", 11'(bus.at_target), 11'd0);

    // saturate at 1023, full-period high
    d_tgt = 1023;
    run_to(1023, 600, "up_1023");
    repeat (5) step();
    chk("sat_1023", 11'(bus.cur_width), 11'd1023);
    step();
    align_period();
    count_period(2000, 1023, cnt);
    chk("pwm_count_1023", 11'(cnt), 11'd1023);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      d_es  = (r < 6);
      d_clr = (r >= 6 && r < 60);
      d_rst = (r == 999);
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 5))
          0:       d_tgt = 0;
          1:       d_tgt = 1023;
          default: d_tgt = int'($urandom_range(0, 1023));
        endcase
      end
      step();
    end
    d_es = 1'b0; d_clr = 1'b0; d_rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter RAMP_DIV, default 1000, clock cycles between ramp steps (>=2).
REQ-002 SHALL have parameter STEP, default 10, width change per ramp step (1..1023).
REQ-003 SHALL have port clock  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port target_width  input  10  commanded duty, sampled every cycle (from motor_control pwm_width).
REQ-006 SHALL have port estop  input  1  level emergency stop (e.g. obstacle closer than 5 units).
REQ-007 SHALL have port estop_clr  input  1  single-cycle pulse that clears a latched stop.
REQ-008 SHALL have port pwm_out  output  1  registered motor PWM drive.
REQ-009 SHALL have port cur_width  output  10  current ramped width.
REQ-010 SHALL have port ramping  output  1  high while in state RAMP.
REQ-011 SHALL have port at_target  output  1  high when cur_width == target_width and state != ESTOP.
REQ-012 SHALL have port estop_active  output  1  high while in state ESTOP.

Function
REQ-013 SHALL run a period counter 0..1022 that wraps to 0, giving a 1023-cycle PWM period.
REQ-014 SHALL load the duty register from cur_width only on the cycle the period counter wraps to 0; the period in progress is never altered, except by REQ-020.
REQ-015 SHALL register pwm_out = (period counter < duty), so duty 0 gives constant low and duty 1023 gives constant high.
REQ-016 SHALL run a tick counter 0..RAMP_DIV-1 that pulses a ramp tick on its terminal count and then wraps.
REQ-017 On a tick with cur_width < target: cur_width = min(cur_width+STEP, target), with an 11-bit intermediate and no overflow.
REQ-018 On a tick with cur_width > target: cur_width = max(cur_width-STEP, target), with no underflow below 0.
REQ-019 SHALL implement the FSM states IDLE, RAMP, HOLD and ESTOP.
- IDLE: cur=0 and target=0.
- RAMP: cur != target.
- HOLD: cur == target != 0.
- Transitions are evaluated every cycle from cur/target; ESTOP has priority over all other states.
REQ-020 When estop is high, on the next edge: state=ESTOP, cur_width=0, duty=0, tick counter=0; pwm_out is low one cycle later.
REQ-021 ESTOP SHALL be exited to IDLE per REQ-026, and ramping SHALL then restart from 0 (no jump to target).
REQ-022 A change in target mid-ramp SHALL take effect on the next tick; the ramp direction may reverse without passing through HOLD.
REQ-023 If estop and a tick occur in the same cycle, estop SHALL win and the cur_width update SHALL be discarded.

Reset
REQ-024 On reset, SHALL force on the next edge: cur_width=0, duty=0, pwm_out=0, both counters=0, state=IDLE, ramping=0, estop_active=0, stop latch=0.
REQ-025 Reset mid-ramp or in ESTOP SHALL override everything; at_target=1 after reset only if target_width=0.

Configuration
REQ-026 SHALL support macro PWM_RAMP_ESTOP_LATCH_EN.
- Defined: ESTOP is held after estop falls until an estop_clr pulse arrives with estop low.
- Undefined: ESTOP exits on the first cycle estop is low, and estop_clr is ignored.

Verification (RAMP_DIV=4, STEP=10)
REQ-027 Reset, then target=25: cur_width steps 0->10->20->25 on three ticks 4 cycles apart; ramping=1 until 25, then HOLD with at_target=1.
REQ-028 cur=1000 in HOLD, target=3: cur_width steps down by 10 per tick to 10, then to 3 (no underflow); the last step is 7.
REQ-029 Duty=300: pwm_out is high for exactly 300 of 1023 cycles; a cur_width change mid-period only affects the following period.
REQ-030 cur=500, estop pulses 1 cycle: cur_width=0 and estop_active=1 next edge, pwm_out=0 the cycle after.
- With the latch macro, stays stopped until estop_clr.
- Without it, re-ramps from 0 immediately.
REQ-031 estop coincident with a tick: cur_width=0, not 0+STEP; assert reset mid-ramp at cur=40: all outputs at reset values next edge.
REQ-032 target=1023: cur saturates at 1023 (no wrap) and pwm_out stays high for the full period.
